// File: rtl/reservation_station_pkg.sv
// Shared Tomasulo types for the reservation stations and their neighbours.
// Holds the width constants, operation class, ROB tag type, station state
// and operand record, plus the CDB tag-match helper used by operand slots.
package tomasula_types;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 3;

  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ADD    = 3'd1,
    OP_SUB    = 3'd2,
    OP_LOGIC  = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_SLT    = 3'd5,
    OP_LUI    = 3'd6,
    OP_BRANCH = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } rs_state_t;

  typedef struct packed {
    logic     valid;
    rob_tag_t tag;
    xlen_t    data;
  } rs_operand_t;

  function automatic logic cdb_hit(input logic cdb_valid, input rob_tag_t cdb_tag,
                                   input rob_tag_t tag);
    return cdb_valid && (cdb_tag == tag);
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch / CDB / issue bundle of one reservation station.
// slave  : the station (receives dispatch, CDB and fu_ready; drives empty/fu_*)
// master : the surroundings (IQ, CDB, functional unit)
interface reservation_station_if;
  import tomasula_types::*;

  logic     flush_i;
  logic     load_i;
  op_t      op_i;
  logic [2:0] funct3_i;
  logic     funct7_i;
  rob_tag_t rob_tag_i;
  logic     src1_valid_i;
  xlen_t    src1_data_i;
  rob_tag_t src1_tag_i;
  logic     src2_valid_i;
  xlen_t    src2_data_i;
  rob_tag_t src2_tag_i;
  logic     cdb_valid_i;
  rob_tag_t cdb_tag_i;
  xlen_t    cdb_data_i;
  logic     fu_ready_i;
  logic     empty_o;
  logic     fu_valid_o;
  op_t      fu_op_o;
  logic [2:0] fu_funct3_o;
  logic     fu_funct7_o;
  xlen_t    fu_src1_o;
  xlen_t    fu_src2_o;
  rob_tag_t fu_rob_tag_o;

  modport slave (
    input  flush_i, load_i, op_i, funct3_i, funct7_i, rob_tag_i,
           src1_valid_i, src1_data_i, src1_tag_i,
           src2_valid_i, src2_data_i, src2_tag_i,
           cdb_valid_i, cdb_tag_i, cdb_data_i, fu_ready_i,
    output empty_o, fu_valid_o, fu_op_o, fu_funct3_o, fu_funct7_o,
           fu_src1_o, fu_src2_o, fu_rob_tag_o
  );

  modport master (
    output flush_i, load_i, op_i, funct3_i, funct7_i, rob_tag_i,
           src1_valid_i, src1_data_i, src1_tag_i,
           src2_valid_i, src2_data_i, src2_tag_i,
           cdb_valid_i, cdb_tag_i, cdb_data_i, fu_ready_i,
    input  empty_o, fu_valid_o, fu_op_o, fu_funct3_o, fu_funct7_o,
           fu_src1_o, fu_src2_o, fu_rob_tag_o
  );

endinterface

// File: rtl/reservation_station_operand_slot.sv
// rs_operand_slot: one source operand of a reservation station.
// Captures the operand on load (with same-cycle CDB bypass) and snoops the
// CDB while the station waits.
// Ports: clk, rst_n; clr_i clears; load_i captures src_*; snoop_i enables
// CDB capture; cdb_*; ld_valid_o = operand valid after load bypass;
// valid_o/data_o = stored operand including a same-cycle CDB hit.
module rs_operand_slot
  import tomasula_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr_i,
  input  logic     load_i,
  input  logic     snoop_i,
  input  logic     src_valid_i,
  input  xlen_t    src_data_i,
  input  rob_tag_t src_tag_i,
  input  logic     cdb_valid_i,
  input  rob_tag_t cdb_tag_i,
  input  xlen_t    cdb_data_i,
  output logic     ld_valid_o,
  output logic     valid_o,
  output xlen_t    data_o
);

  rs_operand_t opnd_q, opnd_d;
  logic        bypass_hit, snoop_hit;

  assign bypass_hit = !src_valid_i && cdb_hit(cdb_valid_i, cdb_tag_i, src_tag_i);
  assign snoop_hit  = snoop_i && !opnd_q.valid && cdb_hit(cdb_valid_i, cdb_tag_i, opnd_q.tag);

  assign ld_valid_o = src_valid_i || bypass_hit;
  assign valid_o    = opnd_q.valid || snoop_hit;
  assign data_o     = snoop_hit ? cdb_data_i : opnd_q.data;

  always_comb begin
    opnd_d = opnd_q;
    if (clr_i) begin
      opnd_d = '0;
    end else if (load_i) begin
      opnd_d.valid = ld_valid_o;
      opnd_d.tag   = src_tag_i;
      opnd_d.data  = bypass_hit ? cdb_data_i : src_data_i;
    end else if (snoop_hit) begin
      opnd_d.valid = 1'b1;
      opnd_d.data  = cdb_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) opnd_q <= '0;
    else        opnd_q <= opnd_d;
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: single-entry Tomasulo reservation station.
// Holds one micro-op with its ROB tag and two operands, wakes them from the
// CDB and issues to the FU with a valid/ready handshake.
// Ports: clk, rst_n (async, active low); rs = reservation_station_if.slave
// carrying dispatch (load/op/src*), CDB, flush and the FU issue interface.
// Build option: RS_EARLY_WAKE_EN lets a WAIT entry issue in the same cycle
// the CDB supplies its last operand, with that operand taken from the CDB.
//
// state | meaning
// EMPTY | entry free, accepts a dispatch
// WAIT  | entry holds an op with at least one operand outstanding
// READY | both operands present, requesting issue
module reservation_station
  import tomasula_types::*;
(
  input logic                  clk,
  input logic                  rst_n,
  reservation_station_if.slave rs
);

  rs_state_t  state_q, state_d;
  op_t        op_q;
  logic [2:0] funct3_q;
  logic       funct7_q;
  rob_tag_t   rob_tag_q;

  logic  load_acc, issue_hs, clr, fu_valid, all_valid;
  logic  s1_ld_valid, s2_ld_valid, s1_valid, s2_valid;
  xlen_t s1_data, s2_data;

  // A flush in the load cycle wins over the dispatch.
  assign load_acc = rs.load_i && (state_q == EMPTY) && !rs.flush_i;
  assign all_valid = s1_valid && s2_valid;

`ifdef RS_EARLY_WAKE_EN
  assign fu_valid = (state_q == READY) || ((state_q == WAIT) && all_valid);
`else
  assign fu_valid = (state_q == READY);
`endif

  assign issue_hs = fu_valid && rs.fu_ready_i;
  assign clr      = rs.flush_i || issue_hs;

  rs_operand_slot u_src1 (
    .clk, .rst_n, .clr_i(clr), .load_i(load_acc), .snoop_i(state_q == WAIT),
    .src_valid_i(rs.src1_valid_i), .src_data_i(rs.src1_data_i), .src_tag_i(rs.src1_tag_i),
    .cdb_valid_i(rs.cdb_valid_i), .cdb_tag_i(rs.cdb_tag_i), .cdb_data_i(rs.cdb_data_i),
    .ld_valid_o(s1_ld_valid), .valid_o(s1_valid), .data_o(s1_data)
  );

  rs_operand_slot u_src2 (
    .clk, .rst_n, .clr_i(clr), .load_i(load_acc), .snoop_i(state_q == WAIT),
    .src_valid_i(rs.src2_valid_i), .src_data_i(rs.src2_data_i), .src_tag_i(rs.src2_tag_i),
    .cdb_valid_i(rs.cdb_valid_i), .cdb_tag_i(rs.cdb_tag_i), .cdb_data_i(rs.cdb_data_i),
    .ld_valid_o(s2_ld_valid), .valid_o(s2_valid), .data_o(s2_data)
  );

  always_comb begin
    state_d = state_q;
    if (rs.flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (rs.load_i) state_d = (s1_ld_valid && s2_ld_valid) ? READY : WAIT;
        WAIT:    if (all_valid) state_d = issue_hs ? EMPTY : READY;
        READY:   if (issue_hs)  state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      op_q      <= OP_NOP;
      funct3_q  <= '0;
      funct7_q  <= 1'b0;
      rob_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        op_q      <= OP_NOP;
        funct3_q  <= '0;
        funct7_q  <= 1'b0;
        rob_tag_q <= '0;
      end else if (load_acc) begin
        op_q      <= rs.op_i;
        funct3_q  <= rs.funct3_i;
        funct7_q  <= rs.funct7_i;
        rob_tag_q <= rs.rob_tag_i;
      end
    end
  end

  // Outside an issue request the FU sees all-zero fields.
  assign rs.empty_o      = (state_q == EMPTY);
  assign rs.fu_valid_o   = fu_valid;
  assign rs.fu_op_o      = fu_valid ? op_q : OP_NOP;
  assign rs.fu_funct3_o  = fu_valid ? funct3_q : 3'd0;
  assign rs.fu_funct7_o  = fu_valid && funct7_q;
  assign rs.fu_src1_o    = fu_valid ? s1_data : '0;
  assign rs.fu_src2_o    = fu_valid ? s2_data : '0;
  assign rs.fu_rob_tag_o = fu_valid ? rob_tag_q : '0;

  a_no_load_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(rs.load_i && !rs.flush_i && (state_q != EMPTY)));

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
  import tomasula_types::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reservation_station_if bus();
  reservation_station dut (.clk(clk), .rst_n(rst_n), .rs(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference entry: occupied flag, op fields and per-operand (valid, tag, data).
  logic       m_occ;
  op_t        m_op;
  logic [2:0] m_f3;
  logic       m_f7;
  rob_tag_t   m_rt;
  logic [1:0] m_v;
  xlen_t      m_d [2];
  rob_tag_t   m_t [2];
  logic       e_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_occ = 1'b0; m_op = OP_NOP; m_f3 = '0; m_f7 = 1'b0; m_rt = '0;
    m_v = '0; m_d[0] = '0; m_d[1] = '0; m_t[0] = '0; m_t[1] = '0;
  endtask

  function automatic logic hit(input int i);
    return m_occ && !m_v[i] && bus.cdb_valid_i && (bus.cdb_tag_i == m_t[i]);
  endfunction

  task automatic check_outputs();
    xlen_t d0, d1;
`ifdef RS_EARLY_WAKE_EN
    e_valid = m_occ && (m_v[0] || hit(0)) && (m_v[1] || hit(1));
    d0 = hit(0) ? bus.cdb_data_i : m_d[0];
    d1 = hit(1) ? bus.cdb_data_i : m_d[1];
`else
    e_valid = m_occ && m_v[0] && m_v[1];
    d0 = m_d[0];
    d1 = m_d[1];
`endif
    chk("empty", bus.empty_o, !m_occ);
    chk("fu_valid", bus.fu_valid_o, e_valid);
    chk("fu_op", bus.fu_op_o, e_valid ? m_op : OP_NOP);
    chk("fu_funct3", bus.fu_funct3_o, e_valid ? m_f3 : 3'd0);
    chk("fu_funct7", bus.fu_funct7_o, e_valid ? m_f7 : 1'b0);
    chk("fu_src1", bus.fu_src1_o, e_valid ? d0 : '0);
    chk("fu_src2", bus.fu_src2_o, e_valid ? d1 : '0);
    chk("fu_rob_tag", bus.fu_rob_tag_o, e_valid ? m_rt : '0);
  endtask

  task automatic model_update();
    logic       sv [2];
    xlen_t      sd [2];
    rob_tag_t   st [2];
    logic [1:0] hits;
    hits = {hit(1), hit(0)};
    if (bus.flush_i) begin
      model_clear();
    end else if (e_valid && bus.fu_ready_i) begin
      model_clear();
    end else if (bus.load_i && !m_occ) begin
      sv[0] = bus.src1_valid_i; sd[0] = bus.src1_data_i; st[0] = bus.src1_tag_i;
      sv[1] = bus.src2_valid_i; sd[1] = bus.src2_data_i; st[1] = bus.src2_tag_i;
      m_occ = 1'b1; m_op = bus.op_i; m_f3 = bus.funct3_i; m_f7 = bus.funct7_i;
      m_rt = bus.rob_tag_i;
      for (int i = 0; i < 2; i++) begin
        m_t[i] = st[i];
        if (sv[i]) begin
          m_v[i] = 1'b1; m_d[i] = sd[i];
        end else if (bus.cdb_valid_i && bus.cdb_tag_i == st[i]) begin
          m_v[i] = 1'b1; m_d[i] = bus.cdb_data_i;
        end else begin
          m_v[i] = 1'b0; m_d[i] = '0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++)
        if (hits[i]) begin
          m_v[i] = 1'b1; m_d[i] = bus.cdb_data_i;
        end
    end
  endtask

  // Caller drives inputs just after a falling edge; this checks, advances
  // the model and returns at the next falling edge.
  task automatic cycle();
    #1 check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.flush_i = 1'b0; bus.load_i = 1'b0; bus.cdb_valid_i = 1'b0; bus.fu_ready_i = 1'b0;
  endtask

  task automatic dispatch(input op_t op, input logic [2:0] f3, input logic f7,
                          input rob_tag_t rt, input logic v1, input xlen_t d1,
                          input rob_tag_t t1, input logic v2, input xlen_t d2,
                          input rob_tag_t t2);
    bus.load_i = 1'b1; bus.op_i = op; bus.funct3_i = f3; bus.funct7_i = f7;
    bus.rob_tag_i = rt;
    bus.src1_valid_i = v1; bus.src1_data_i = d1; bus.src1_tag_i = t1;
    bus.src2_valid_i = v2; bus.src2_data_i = d2; bus.src2_tag_i = t2;
  endtask

  task automatic cdb(input logic v, input rob_tag_t t, input xlen_t d);
    bus.cdb_valid_i = v; bus.cdb_tag_i = t; bus.cdb_data_i = d;
  endtask

  task automatic drain();
    bus.fu_ready_i = 1'b1;
    cycle();
    idle();
    chk("drain_empty", bus.empty_o, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    dispatch(OP_NOP, 3'd0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    bus.load_i = 1'b0;
    cdb(1'b0, '0, '0);
    model_clear();
    @(negedge clk);
    #1;
    chk("rst_empty", bus.empty_o, 1'b1);
    chk("rst_fu_valid", bus.fu_valid_o, 1'b0);
    chk("rst_src1", bus.fu_src1_o, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both operands ready; FU stalls for 3 cycles.
    dispatch(OP_ADD, 3'd0, 1'b0, 3'd2, 1'b1, 32'd5, 3'd0, 1'b1, 32'd7, 3'd0);
    cycle();
    idle();
    chk("add_valid", bus.fu_valid_o, 1'b1);
    chk("add_src1", bus.fu_src1_o, 32'd5);
    chk("add_src2", bus.fu_src2_o, 32'd7);
    chk("add_tag", bus.fu_rob_tag_o, 3'd2);
    repeat (3) cycle();
    chk("add_stall_src1", bus.fu_src1_o, 32'd5);
    drain();

    // Wait on tag 4; wrong tag 3 is ignored.
    dispatch(OP_SUB, 3'd0, 1'b1, 3'd3, 1'b0, '0, 3'd4, 1'b1, 32'd9, 3'd0);
    cycle();
    idle();
    cdb(1'b1, 3'd3, 32'h5555);
    cycle();
    idle();
    chk("wait_no_capture", bus.fu_valid_o, 1'b0);
    cdb(1'b1, 3'd4, 32'h1234);
`ifdef RS_EARLY_WAKE_EN
    #1;
    chk("early_valid", bus.fu_valid_o, 1'b1);
    chk("early_src1", bus.fu_src1_o, 32'h1234);
`endif
    cycle();
    idle();
    chk("wake_valid", bus.fu_valid_o, 1'b1);
    chk("wake_src1", bus.fu_src1_o, 32'h1234);
    chk("wake_src2", bus.fu_src2_o, 32'd9);
    drain();

    // Load-cycle bypass.
    dispatch(OP_LOGIC, 3'd7, 1'b0, 3'd5, 1'b0, '0, 3'd6, 1'b1, 32'd1, 3'd0);
    cdb(1'b1, 3'd6, 32'hDEAD);
    cycle();
    idle();
    chk("bypass_valid", bus.fu_valid_o, 1'b1);
    chk("bypass_src1", bus.fu_src1_o, 32'hDEAD);
    drain();

    // Both operands wake from one broadcast.
    dispatch(OP_SHIFT, 3'd1, 1'b0, 3'd0, 1'b0, '0, 3'd1, 1'b0, '0, 3'd1);
    cycle();
    idle();
    cdb(1'b1, 3'd1, 32'hABCD);
    cycle();
    idle();
    chk("dual_valid", bus.fu_valid_o, 1'b1);
    chk("dual_src1", bus.fu_src1_o, 32'hABCD);
    chk("dual_src2", bus.fu_src2_o, 32'hABCD);
    drain();

    // Flush while waiting; a later matching broadcast must not revive it.
    dispatch(OP_SLT, 3'd2, 1'b0, 3'd4, 1'b0, '0, 3'd7, 1'b1, 32'd3, 3'd0);
    cycle();
    idle();
    bus.flush_i = 1'b1;
    cycle();
    idle();
    chk("flush_empty", bus.empty_o, 1'b1);
    cdb(1'b1, 3'd7, 32'h77);
    cycle();
    idle();
    chk("flush_stays_empty", bus.empty_o, 1'b1);

    // Asynchronous reset while READY.
    dispatch(OP_ADD, 3'd0, 1'b0, 3'd6, 1'b1, 32'd11, 3'd0, 1'b1, 32'd12, 3'd0);
    cycle();
    idle();
    chk("pre_rst_valid", bus.fu_valid_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_empty", bus.empty_o, 1'b1);
    chk("async_rst_valid", bus.fu_valid_o, 1'b0);
    chk("async_rst_src1", bus.fu_src1_o, '0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      idle();
      bus.flush_i    = ($urandom_range(19) == 0);
      bus.fu_ready_i = $urandom_range(1);
      if (!m_occ && $urandom_range(1) == 1) begin
        dispatch(op_t'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                 rob_tag_t'($urandom_range(7)),
                 1'($urandom_range(1)), xlen_t'($urandom), rob_tag_t'($urandom_range(7)),
                 1'($urandom_range(1)), xlen_t'($urandom), rob_tag_t'($urandom_range(7)));
      end
      if ($urandom_range(1) == 1) begin
        if (m_occ && $urandom_range(9) < 7)
          cdb(1'b1, m_t[$urandom_range(1)], xlen_t'($urandom));
        else if (bus.load_i && $urandom_range(1) == 1)
          cdb(1'b1, bus.src1_tag_i, xlen_t'($urandom));
        else
          cdb(1'b1, rob_tag_t'($urandom_range(7)), xlen_t'($urandom));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Single-entry reservation station downstream of the instruction queue; four instances (res1..res4) sit between the IQ and the ALU-class functional units.
- Captures one dispatched micro-op together with its ROB destination tag and two source operands. Each operand arrives either as ready data or as a producer ROB tag.
- Snoops the common data bus (CDB) to wake up waiting operands, then issues to its FU with a valid/ready handshake.
- Reports `empty_o` back to the IQ for routing.

Parameters:
- XLEN, 32, operand/data width
- ROB_TAG_W, 3, ROB tag width (8-entry ROB)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush (mispredict); synchronous clear of the entry
- load_i  in  1  dispatch strobe from IQ (resN_load)
- op_i  in  tomasula_types::op_t  operation class
- funct3_i  in  3  funct3
- funct7_i  in  1  funct7 bit (bit 30 of the instruction)
- rob_tag_i  in  ROB_TAG_W  destination tag allocated by the ROB
- src1_valid_i  in  1  1 = src1_data_i holds the value; 0 = wait on src1_tag_i
- src1_data_i  in  XLEN  src1 value
- src1_tag_i  in  ROB_TAG_W  src1 producer tag
- src2_valid_i, src2_data_i, src2_tag_i  in  1/XLEN/ROB_TAG_W  same for src2; immediates arrive with valid=1
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  ROB_TAG_W  CDB broadcast tag
- cdb_data_i  in  XLEN  CDB broadcast result
- fu_ready_i  in  1  FU can accept
- empty_o  out  1  entry free (registered)
- fu_valid_o  out  1  issue request
- fu_op_o, fu_funct3_o, fu_funct7_o  out  op_t/3/1  issued op fields
- fu_src1_o, fu_src2_o  out  XLEN  issued operands
- fu_rob_tag_o  out  ROB_TAG_W  destination tag for the FU result

Behaviour:
- Reset (rst_n=0, asynchronous): state EMPTY, empty_o=1, fu_valid_o=0, all stored fields and data outputs 0.
- FSM states:
  - EMPTY -> WAIT on load_i when either operand is invalid after CDB bypass.
  - EMPTY -> READY on load_i when both operands are valid after bypass.
  - WAIT -> READY when the last missing operand is captured from the CDB.
  - READY -> EMPTY on fu_valid_o & fu_ready_i.
  - Any state -> EMPTY on flush_i.
- Priority: reset > flush_i > issue handshake > load_i.
- empty_o = (state==EMPTY), registered; it deasserts the cycle after the load.
- load_i while not EMPTY is ignored and covered by an assertion; the IQ never does this.
- Load-cycle bypass: if load_i and cdb_valid_i, and src*_valid_i=0 with src*_tag_i==cdb_tag_i, store cdb_data_i and mark the operand valid at the same edge. This is mandatory.
- Snoop: in WAIT, each invalid operand whose tag equals cdb_tag_i while cdb_valid_i is set captures cdb_data_i at the clock edge. Both operands may wake in the same cycle.
- Issue: fu_valid_o=1 exactly in READY. All fu_* outputs are driven from stored fields and stay stable until the handshake. fu_* are 0 when not in READY.
- Entry frees at the handshake edge. empty_o=1 the next cycle, so the minimum dispatch-to-dispatch gap per station is 1 bubble.
- Flush: clears the entry at the next edge. An issue handshake in the flush cycle is discarded by the FU, which sees the same flush.
- Tags compare at full ROB_TAG_W width; no wrap handling is needed because the ROB guarantees unique in-flight tags.

Optional Feature:
- Macro: RS_EARLY_WAKE_EN
- Defined:
  - In WAIT, when the CDB supplies the last missing operand, fu_valid_o asserts combinationally in that same cycle, with the woken operand muxed directly from cdb_data_i.
  - A handshake in that cycle frees the entry; otherwise the FSM goes to READY.
- Undefined: fu_valid_o asserts only from READY, one cycle after wakeup.

Decomposition:
- Shared package tomasula_types gains:
  - rs_state_t (EMPTY/WAIT/READY)
  - rob_tag_t (ROB_TAG_W bits)
  - rs_operand_t struct {valid, tag, data}
- One natural sub-module: rs_operand_slot. It holds one operand, applies the load-cycle bypass and CDB snoop, and is instantiated twice.

Test Plan:
- Reset with rst_n=0 mid-READY -> empty_o=1 and fu_valid_o=0 immediately, without waiting for a clock edge.
- Load op=ADD, src1=5, src2=7 (both valid), rob_tag=2 -> READY next cycle, fu_valid_o=1, fu_src1_o=5, fu_src2_o=7, fu_rob_tag_o=2. With fu_ready_i=0 for 3 cycles, outputs stay stable; then fu_ready_i=1 -> empty_o=1 next cycle.
- Load with src1 tag=4 invalid, src2=9 -> WAIT. CDB tag=3 -> no capture. CDB tag=4, data=0x1234 -> READY, fu_src1_o=0x1234.
- Load with src1 tag=6 invalid while the CDB broadcasts tag=6, data=0xDEAD in the same cycle -> READY next cycle, fu_src1_o=0xDEAD.
- Both operands waiting on tag=1; one CDB tag=1 broadcast -> both operands captured, READY.
- flush_i in WAIT -> EMPTY next cycle. Also with RS_EARLY_WAKE_EN: wakeup cycle shows fu_valid_o=1 with fu_src1_o taken from cdb_data_i.
